// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one character ROM between four display slots, with per-slot pattern buffers.
// Optional CHAR_ROM_BLANK_BYPASS_EN: code 31 blanks the slot directly without a ROM cycle.
module char_rom_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [19:0] req_addr,
    output logic [4:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic [31:0] sseg_bus
);

    localparam int unsigned N_SLOTS = 4;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned PAT_W   = 8;
    localparam int unsigned PTR_W   = 2;
    localparam logic [CODE_W-1:0] BLANK_CODE = CODE_W'(31);
    localparam logic [PAT_W-1:0]  BLANK_PAT  = PAT_W'(8'hFF);

    logic [N_SLOTS-1:0][CODE_W-1:0] code_c;
    logic [N_SLOTS-1:0]             byp_req_c;
    logic [N_SLOTS-1:0]             pend_eff_c;
    logic                           found_c;
    logic [PTR_W-1:0]               sel_c;
    logic [PTR_W-1:0]               idx_c;

    logic [N_SLOTS-1:0]             pending_q, pending_d;
    logic [N_SLOTS-1:0][CODE_W-1:0] pend_addr_q, pend_addr_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic [N_SLOTS-1:0]             grant_q, grant_d;
    logic [CODE_W-1:0]              rom_addr_q, rom_addr_d;
    logic [N_SLOTS-1:0]             cap_rom_q, cap_rom_d;
    logic [N_SLOTS-1:0]             cap_byp_q, cap_byp_d;
    logic [N_SLOTS-1:0]             done_q, done_d;
    logic                           busy_q, busy_d;
    logic [N_SLOTS-1:0][PAT_W-1:0]  buf_q, buf_d;

    // Packed layout already matches slot i at bits [5i+4:5i].
    assign code_c = req_addr;

    // Blank-code requests that skip the ROM entirely.
    always_comb begin
        byp_req_c = '0;
`ifdef CHAR_ROM_BLANK_BYPASS_EN
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            byp_req_c[i] = req[i] && (code_c[i] == BLANK_CODE);
        end
`endif
    end

    // Pending capture, round-robin issue and the capture pipeline.
    always_comb begin
        pend_addr_d = pend_addr_q;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (req[i] && !byp_req_c[i]) begin
                pend_addr_d[i] = code_c[i];
            end
        end
        pend_eff_c = (pending_q | req) & ~byp_req_c;

        found_c = 1'b0;
        sel_c   = '0;
        idx_c   = '0;
        for (int k = 1; k <= int'(N_SLOTS); k++) begin
            idx_c = ptr_q + PTR_W'(k);
            if (!found_c && pend_eff_c[idx_c]) begin
                found_c = 1'b1;
                sel_c   = idx_c;
            end
        end

        grant_d    = found_c ? (N_SLOTS'(1) << sel_c) : '0;
        rom_addr_d = found_c ? pend_addr_d[sel_c] : rom_addr_q;
        ptr_d      = found_c ? sel_c : ptr_q;
        pending_d  = pend_eff_c & ~grant_d;

        cap_rom_d = grant_q;
        cap_byp_d = byp_req_c;
        done_d    = cap_rom_d | cap_byp_d;
        busy_d    = (|pending_d) || (|grant_d) || (|done_d);

        // Bypass writes last so it wins over a ROM capture for the same slot.
        buf_d = buf_q;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (cap_rom_q[i]) begin
                buf_d[i] = rom_data;
            end
            if (cap_byp_q[i]) begin
                buf_d[i] = BLANK_PAT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            pend_addr_q <= '0;
            ptr_q       <= PTR_W'(N_SLOTS - 1);
            grant_q     <= '0;
            rom_addr_q  <= '0;
            cap_rom_q   <= '0;
            cap_byp_q   <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            buf_q       <= {N_SLOTS{BLANK_PAT}};
        end else begin
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            rom_addr_q  <= rom_addr_d;
            cap_rom_q   <= cap_rom_d;
            cap_byp_q   <= cap_byp_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            buf_q       <= buf_d;
        end
    end

    assign grant    = grant_q;
    assign rom_addr = rom_addr_q;
    assign done     = done_q;
    assign busy     = busy_q;
    // ROM data only arrives in the done cycle, so the bus shows the pattern being written.
    assign sseg_bus = {buf_d[0], buf_d[1], buf_d[2], buf_d[3]};

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Self-checking bench for char_rom_arbiter: directed vector table plus randomized run against a slot-level model.
module tb_char_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [19:0] req_addr = '0;
    logic [4:0]  rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [31:0] sseg_bus;

`ifdef CHAR_ROM_BLANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    char_rom_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .rom_addr(rom_addr), .rom_data(rom_data), .grant(grant),
        .done(done), .busy(busy), .sseg_bus(sseg_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [4:0] a);
        if (a == 5'd22) return 8'hC0;
        return 8'(int'(a) * 29 + 7);
    endfunction

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_f(rom_addr);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] pa(input int s0, input int s1, input int s2, input int s3);
        return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
    endfunction

    function automatic logic [31:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [19:0] addr;
        logic [3:0]  g;
        logic [4:0]  ra;
        logic [3:0]  d;
        logic        b;
        logic [31:0] ss;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic [19:0] ad,
                                input logic [3:0] g, input int ra, input logic [3:0] d,
                                input logic b, input logic [31:0] ss);
        vec_t v;
        v.rst = r; v.req = rq; v.addr = ad; v.g = g; v.ra = 5'(ra);
        v.d = d; v.b = b; v.ss = ss;
        vecs.push_back(v);
    endfunction

    // Slot-level reference model.
    bit         m_pend[4];
    int         m_paddr[4];
    logic [7:0] m_buf[4];
    int         m_last, m_prev_slot, m_prev_addr;
    logic [3:0] m_grant, m_done;
    logic [4:0] m_ra;
    logic       m_busy;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_paddr[i] = 0; m_buf[i] = 8'hFF;
        end
        m_last = 3; m_prev_slot = -1; m_prev_addr = 0;
        m_grant = '0; m_done = '0; m_ra = '0; m_busy = 1'b0;
    endfunction

    function automatic void model_step(input logic r, input logic [3:0] rq, input logic [19:0] ad);
        int sel;
        int code;
        bit any;
        if (r) begin
            model_reset();
            return;
        end
        m_done = '0;
        if (m_prev_slot >= 0) begin
            m_done[m_prev_slot] = 1'b1;
            m_buf[m_prev_slot] = rom_f(5'(m_prev_addr));
        end
        for (int i = 0; i < 4; i++) begin
            code = int'(ad[5*i +: 5]);
            if (rq[i]) begin
                if (BYP && code == 31) begin
                    m_pend[i] = 0;
                    m_buf[i] = 8'hFF;
                    m_done[i] = 1'b1;
                end else begin
                    m_pend[i] = 1;
                    m_paddr[i] = code;
                end
            end
        end
        sel = -1;
        for (int k = 1; k <= 4; k++) begin
            if (sel < 0 && m_pend[(m_last + k) % 4]) sel = (m_last + k) % 4;
        end
        m_grant = '0;
        if (sel >= 0) begin
            m_grant[sel] = 1'b1;
            m_ra = 5'(m_paddr[sel]);
            m_pend[sel] = 0;
            m_last = sel;
        end
        m_prev_slot = sel;
        m_prev_addr = int'(m_ra);
        any = 0;
        for (int i = 0; i < 4; i++) any = any | m_pend[i];
        m_busy = any || (m_grant != 0) || (m_done != 0);
    endfunction

    initial begin
        logic [7:0]  r1, r2, r3, r4, r9, r10, r11, r16, r31, c0, ff;
        logic [31:0] ss;
        r1 = rom_f(5'd1); r2 = rom_f(5'd2); r3 = rom_f(5'd3); r4 = rom_f(5'd4);
        r9 = rom_f(5'd9); r10 = rom_f(5'd10); r11 = rom_f(5'd11); r16 = rom_f(5'd16);
        r31 = rom_f(5'd31); c0 = 8'hC0; ff = 8'hFF;

        // reset and single fetch
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 32'hFFFF_FFFF);
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 32'hFFFF_FFFF);
        add(0, 4'b0001, pa(22,0,0,0), 4'b0001, 22, 4'b0000, 1, 32'hFFFF_FFFF);
        add(0, 4'b0000, 0, 4'b0000, 22, 4'b0001, 1, pk(c0,ff,ff,ff));
        add(0, 4'b0000, 0, 4'b0000, 22, 4'b0000, 0, pk(c0,ff,ff,ff));
        // round robin from reset
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 32'hFFFF_FFFF);
        add(0, 4'b1111, pa(1,2,3,4), 4'b0001, 1, 4'b0000, 1, 32'hFFFF_FFFF);
        add(0, 4'b0000, 0, 4'b0010, 2, 4'b0001, 1, pk(r1,ff,ff,ff));
        add(0, 4'b0000, 0, 4'b0100, 3, 4'b0010, 1, pk(r1,r2,ff,ff));
        add(0, 4'b0000, 0, 4'b1000, 4, 4'b0100, 1, pk(r1,r2,r3,ff));
        add(0, 4'b0000, 0, 4'b0000, 4, 4'b1000, 1, pk(r1,r2,r3,r4));
        add(0, 4'b0000, 0, 4'b0000, 4, 4'b0000, 0, pk(r1,r2,r3,r4));
        // overwrite of a pending slot-2 code
        add(0, 4'b0111, pa(10,11,5,0), 4'b0001, 10, 4'b0000, 1, pk(r1,r2,r3,r4));
        add(0, 4'b0100, pa(0,0,9,0), 4'b0010, 11, 4'b0001, 1, pk(r10,r2,r3,r4));
        add(0, 4'b0000, 0, 4'b0100, 9, 4'b0010, 1, pk(r10,r11,r3,r4));
        add(0, 4'b0000, 0, 4'b0000, 9, 4'b0100, 1, pk(r10,r11,r9,r4));
        add(0, 4'b0000, 0, 4'b0000, 9, 4'b0000, 0, pk(r10,r11,r9,r4));
        // request colliding with its own grant
        add(0, 4'b0010, pa(0,3,0,0), 4'b0010, 3, 4'b0000, 1, pk(r10,r11,r9,r4));
        add(0, 4'b0010, pa(0,16,0,0), 4'b0010, 16, 4'b0010, 1, pk(r10,r3,r9,r4));
        add(0, 4'b0000, 0, 4'b0000, 16, 4'b0010, 1, pk(r10,r16,r9,r4));
        add(0, 4'b0000, 0, 4'b0000, 16, 4'b0000, 0, pk(r10,r16,r9,r4));
        // blank code 31
        if (BYP) begin
            add(0, 4'b1000, pa(0,0,0,31), 4'b0000, 16, 4'b1000, 1, pk(r10,r16,r9,ff));
            add(0, 4'b0000, 0, 4'b0000, 16, 4'b0000, 0, pk(r10,r16,r9,ff));
            ss = pk(r10,r16,r9,ff);
        end else begin
            add(0, 4'b1000, pa(0,0,0,31), 4'b1000, 31, 4'b0000, 1, pk(r10,r16,r9,r4));
            add(0, 4'b0000, 0, 4'b0000, 31, 4'b1000, 1, pk(r10,r16,r9,r31));
            add(0, 4'b0000, 0, 4'b0000, 31, 4'b0000, 0, pk(r10,r16,r9,r31));
            ss = pk(r10,r16,r9,r31);
        end
        // reset while a fetch is in flight
        add(0, 4'b0001, pa(7,0,0,0), 4'b0001, 7, 4'b0000, 1, ss);
        add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 32'hFFFF_FFFF);
        add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 32'hFFFF_FFFF);
        add(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0, 32'hFFFF_FFFF);

        for (int n = 0; n < vecs.size(); n++) begin
            rst = vecs[n].rst; req = vecs[n].req; req_addr = vecs[n].addr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d grant", n), 32'(grant), 32'(vecs[n].g));
            chk($sformatf("vec%0d rom_addr", n), 32'(rom_addr), 32'(vecs[n].ra));
            chk($sformatf("vec%0d done", n), 32'(done), 32'(vecs[n].d));
            chk($sformatf("vec%0d busy", n), 32'(busy), 32'(vecs[n].b));
            chk($sformatf("vec%0d sseg", n), sseg_bus, vecs[n].ss);
        end

        // randomized traffic against the model
        rst = 1'b1; req = '0; req_addr = '0;
        model_step(1'b1, '0, '0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 600; n++) begin
            logic [3:0]  rq;
            logic [19:0] ad;
            logic        r;
            r  = ($urandom_range(0, 199) == 0);
            rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                ad[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
            end
            rst = r; req = rq; req_addr = ad;
            model_step(r, rq, ad);
            @(posedge clk);
            #1;
            chk("rnd grant", 32'(grant), 32'(m_grant));
            chk("rnd rom_addr", 32'(rom_addr), 32'(m_ra));
            chk("rnd done", 32'(done), 32'(m_done));
            chk("rnd busy", 32'(busy), 32'(m_busy));
            chk("rnd sseg", sseg_bus, pk(m_buf[0], m_buf[1], m_buf[2], m_buf[3]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/char_rom_arbiter.md
CHAR_ROM_ARBITER -- requirements
Module: char_rom_arbiter

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req  input  4  per-slot fetch request pulses; bit i = display slot i.
REQ-005 req_addr  input  20  per-slot character codes, 5 bits each; slot i at bits [5i+4:5i].
REQ-006 rom_addr  output  5  address to the single shared character ROM.
REQ-007 rom_data  input  8  ROM output; valid exactly 1 cycle after rom_addr is presented.
REQ-008 grant  output  4  one-hot, 1-cycle pulse marking the slot whose fetch issues this cycle.
REQ-009 done  output  4  one-hot, 1-cycle pulse marking the slot whose pattern was written this cycle.
REQ-010 busy  output  1  high while any fetch is pending or in flight.
REQ-011 sseg_bus  output  32  buffered segment patterns {slot0, slot1, slot2, slot3}; slot0 in bits [31:24].

Function
REQ-012 Each req[i] pulse SHALL set pending[i] and capture req_addr slot i into pend_addr[i].
REQ-013 req[i] while pending[i] is already set SHALL overwrite pend_addr[i] with the newer code; only one fetch results.
REQ-014 Issue stage: in any cycle with pending nonzero, exactly one slot SHALL be selected, rom_addr driven with its pend_addr, grant bit pulsed and pending bit cleared.
REQ-015 Selection SHALL be round-robin: search starts at the slot after the last granted one, wrapping 3 -> 0.
REQ-016 Capture stage: one cycle after a grant to slot i, rom_data SHALL be written to buffer[i] and done[i] pulsed.
REQ-017 Pipelined throughput: one issue per cycle; issue and capture for different slots SHALL overlap without stalls.
REQ-018 req[i] in the same cycle as grant[i] SHALL leave pending[i] set with the new code, causing a second fetch later.
REQ-019 With pending zero, rom_addr SHALL hold its last value and grant SHALL be 0.
REQ-020 busy = (pending != 0) OR capture stage valid.
REQ-021 sseg_bus SHALL change only on a capture-stage write; other slots are untouched.

Reset
REQ-022 On rst: pending=0, capture valid=0, grant=0, done=0, busy=0, rom_addr=0, round-robin pointer so slot 0 has highest priority.
REQ-023 On rst: every buffer byte = 8'hFF (all segments off, active-low), so sseg_bus = 32'hFFFF_FFFF.
REQ-024 rst mid-fetch SHALL discard the in-flight capture; no done pulse after reset release for pre-reset requests.

Configuration
REQ-025 Macro CHAR_ROM_BLANK_BYPASS_EN compiled in: a req[i] with code 31 SHALL clear pending[i], write 8'hFF to buffer[i] on the next cycle with a done[i] pulse, and never issue a grant or ROM cycle.
REQ-026 Without CHAR_ROM_BLANK_BYPASS_EN: code 31 SHALL be fetched from ROM like any other code.
REQ-027 If the bypass write and a ROM capture target different slots in the same cycle, both SHALL complete; for the same slot the bypass write SHALL win.

Verification
REQ-028 Reset: assert rst -> sseg_bus=32'hFFFF_FFFF, grant=0, done=0, busy=0, rom_addr=0.
REQ-029 Single: req=4'b0001, slot0 code 22, ROM model returns 8'hC0 -> grant=0001 cycle+1, done=0001 and sseg_bus[31:24]=8'hC0 cycle+2.
REQ-030 Round-robin: req=4'b1111 in one cycle -> grants 0001,0010,0100,1000 on consecutive cycles; done follows each by 1 cycle; busy falls after last done.
REQ-031 Overwrite: req[2] code 5 then req[2] code 9 before grant -> one grant[2], rom_addr=9, one done[2].
REQ-032 Collision: req[1] code 16 in the grant[1] cycle of a prior code-3 fetch -> two fetches, buffer[1] ends with pattern for 16.
REQ-033 Bypass (macro on): req[3] code 31 -> no grant, done[3] next cycle, sseg_bus[7:0]=8'hFF; macro off -> grant[3] with rom_addr=31.
